// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit seven-segment scanner.
// A packed hex value is captured into a shadow register on load and
// moved into the display register only at the end of a full frame, so
// a frame is never shown half old / half new.  Each digit slot opens
// with a blanking window to hide segment ghosting while the anode
// switches.  All visible outputs are registered, one cycle behind the
// scan state.
module seg7_scan_driver #(
    parameter int unsigned N_DIGITS   = 4,
    parameter int unsigned DIV        = 1000,
    parameter int unsigned BLANK      = 16,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  load,
    input  logic                  lz_en,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    // Scan position
    logic [CNT_W-1:0]      r_div_cnt;
    logic [IDX_W-1:0]      r_dig_idx;

    // Shadow (written by load) and display (drives the outputs)
    logic [4*N_DIGITS-1:0] r_sh_value;
    logic [N_DIGITS-1:0]   r_sh_dp;
    logic                  r_sh_lz;
    logic [4*N_DIGITS-1:0] r_disp_value;
    logic [N_DIGITS-1:0]   r_disp_dp;
    logic                  r_disp_lz;

    // Registered outputs
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [N_DIGITS-1:0]   r_an;
    logic                  r_frame_tick;

    // Combinational scan decode
    logic                  w_slot_end;
    logic                  w_frame_end;
    logic                  w_blank;
    logic                  w_run;
    logic [N_DIGITS-1:0]   w_zero_run;
    logic [3:0]            w_nibble;
    logic                  w_dp_sel;
    logic [N_DIGITS-1:0]   w_an_sel;
    logic                  w_supp;
    logic [6:0]            w_seg_hi;
    logic                  w_dp_hi;
    logic [N_DIGITS-1:0]   w_an_hi;

    // Hex font, active-high, {a,b,c,d,e,f,g}
    function automatic logic [6:0] font(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0:    code = 7'h7E;
            4'h1:    code = 7'h30;
            4'h2:    code = 7'h6D;
            4'h3:    code = 7'h79;
            4'h4:    code = 7'h33;
            4'h5:    code = 7'h5B;
            4'h6:    code = 7'h5F;
            4'h7:    code = 7'h70;
            4'h8:    code = 7'h7F;
            4'h9:    code = 7'h7B;
            4'hA:    code = 7'h77;
            4'hB:    code = 7'h1F;
            4'hC:    code = 7'h4E;
            4'hD:    code = 7'h3D;
            4'hE:    code = 7'h4F;
            default: code = 7'h47;
        endcase
        return code;
    endfunction

    assign w_slot_end  = (r_div_cnt == CNT_LAST);
    assign w_frame_end = w_slot_end && (r_dig_idx == IDX_LAST);

    generate
        if (BLANK == 0) begin : g_no_blank
            assign w_blank = 1'b0;
        end else begin : g_blank
            assign w_blank = (r_div_cnt < CNT_W'(BLANK));
        end
    endgenerate

    // Zero-run from the top digit down: bit i set when nibble i and every higher nibble are 0
    always_comb begin
        w_zero_run = '0;
        w_run      = 1'b1;
        for (int unsigned i = N_DIGITS; i > 0; i--) begin
            w_run           = w_run && (r_disp_value[4*(i-1) +: 4] == 4'h0);
            w_zero_run[i-1] = w_run;
        end
    end

    // Select the nibble, decimal point and anode of the digit being scanned
    always_comb begin
        w_nibble = 4'h0;
        w_dp_sel = 1'b0;
        w_an_sel = '0;
        w_supp   = 1'b0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (r_dig_idx == IDX_W'(i)) begin
                w_nibble    = r_disp_value[4*i +: 4];
                w_dp_sel    = r_disp_dp[i];
                w_an_sel[i] = 1'b1;
                w_supp      = r_disp_lz && (i != 0) && w_zero_run[i];
            end
        end
    end

    // Active-high output values before the polarity flip
    always_comb begin
        w_seg_hi = (w_blank || w_supp) ? 7'h00 : font(w_nibble);
        w_dp_hi  = w_blank ? 1'b0 : w_dp_sel;
        w_an_hi  = w_blank ? '0 : w_an_sel;
    end

    // Slot divider and digit index; the index only moves when the divider wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_dig_idx <= '0;
        end else if (w_slot_end) begin
            r_div_cnt <= '0;
            r_dig_idx <= (r_dig_idx == IDX_LAST) ? '0 : r_dig_idx + IDX_W'(1);
        end else begin
            r_div_cnt <= r_div_cnt + CNT_W'(1);
        end
    end

    // Shadow capture on load; display refresh at the frame boundary, bypassing the shadow on a coincident load
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_value   <= '0;
            r_sh_dp      <= '0;
            r_sh_lz      <= 1'b0;
            r_disp_value <= '0;
            r_disp_dp    <= '0;
            r_disp_lz    <= 1'b0;
        end else begin
            if (load) begin
                r_sh_value <= value;
                r_sh_dp    <= dp_in;
                r_sh_lz    <= lz_en;
            end
            if (w_frame_end) begin
                r_disp_value <= load ? value : r_sh_value;
                r_disp_dp    <= load ? dp_in : r_sh_dp;
                r_disp_lz    <= load ? lz_en : r_sh_lz;
            end
        end
    end

    // Output register: inactive level on reset, otherwise the decoded slot with polarity applied
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg        <= {7{ACTIVE_LOW}};
            r_dp         <= ACTIVE_LOW;
            r_an         <= {N_DIGITS{ACTIVE_LOW}};
            r_frame_tick <= 1'b0;
        end else begin
            r_seg        <= w_seg_hi ^ {7{ACTIVE_LOW}};
            r_dp         <= w_dp_hi ^ ACTIVE_LOW;
            r_an         <= w_an_hi ^ {N_DIGITS{ACTIVE_LOW}};
            r_frame_tick <= w_frame_end;
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (N_DIGITS=4, DIV=8, BLANK=2), one active-high
// and one active-low instance driven from the same inputs.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic        lz_en;

    logic [6:0]  seg_h, seg_l;
    logic        dp_h, dp_l;
    logic [3:0]  an_h, an_l;
    logic        ft_h, ft_l;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .N_DIGITS   (4),
        .DIV        (8),
        .BLANK      (2),
        .ACTIVE_LOW (1'b0)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp_in      (dp_in),
        .load       (load),
        .lz_en      (lz_en),
        .seg        (seg_h),
        .dp         (dp_h),
        .an         (an_h),
        .frame_tick (ft_h)
    );

    seg7_scan_driver #(
        .N_DIGITS   (4),
        .DIV        (8),
        .BLANK      (2),
        .ACTIVE_LOW (1'b1)
    ) u_dut_al (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp_in      (dp_in),
        .load       (load),
        .lz_en      (lz_en),
        .seg        (seg_l),
        .dp         (dp_l),
        .an         (an_l),
        .frame_tick (ft_l)
    );

    // One display setting and the active-high codes it must show per digit
    typedef struct {
        logic [15:0]     value;
        logic [3:0]      dp;
        logic            lz;
        logic [3:0][6:0] seg;   // seg[i] = expected code of digit i
        int unsigned     pos;   // frame position at which it is loaded
    } vec_t;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       ft;
    } exp_t;

    exp_t        sb[$];
    vec_t        tbl[8];
    vec_t        cur;      // expected display contents
    vec_t        pend;     // expected shadow contents
    int unsigned cyc;      // scan state index since reset
    int          pass_cnt = 0;
    int          chk_cnt  = 0;
    string       phase    = "reset";

    function automatic exp_t expect_out(vec_t d, int unsigned k);
        exp_t        e;
        int unsigned pos;
        int unsigned dig;
        pos  = k % 8;
        dig  = (k / 8) % 4;
        e    = '0;
        e.ft = (k % 32 == 31);
        if (pos >= 2) begin
            e.seg = d.seg[dig];
            e.dp  = d.dp[dig];
            e.an  = 4'b0001 << dig;
        end
        return e;
    endfunction

    task automatic check_out();
        exp_t e, e_l, a_h, a_l;
        if (sb.size() == 0) begin
            chk_cnt++;
            $display("FAIL %s scoreboard empty at cyc=%0d", phase, cyc);
            return;
        end
        e   = sb.pop_front();
        e_l = e;
        e_l.seg = ~e.seg;
        e_l.dp  = ~e.dp;
        e_l.an  = ~e.an;
        a_h = {seg_h, dp_h, an_h, ft_h};
        a_l = {seg_l, dp_l, an_l, ft_l};
        chk_cnt++;
        if (a_h === e) pass_cnt++;
        else $display("FAIL %s active_high cyc=%0d got seg=%h dp=%b an=%b ft=%b want seg=%h dp=%b an=%b ft=%b",
                      phase, cyc, a_h.seg, a_h.dp, a_h.an, a_h.ft, e.seg, e.dp, e.an, e.ft);
        chk_cnt++;
        if (a_l === e_l) pass_cnt++;
        else $display("FAIL %s active_low cyc=%0d got seg=%h dp=%b an=%b ft=%b want seg=%h dp=%b an=%b ft=%b",
                      phase, cyc, a_l.seg, a_l.dp, a_l.an, a_l.ft, e_l.seg, e_l.dp, e_l.an, e_l.ft);
    endtask

    // Drive one cycle of stimulus, queue the output it must produce, then compare after the edge
    task automatic step(input logic ld, input vec_t rec, input logic r);
        exp_t e;
        rst   = r;
        load  = ld;
        value = rec.value;
        dp_in = rec.dp;
        lz_en = rec.lz;
        if (r) begin
            e = '0;
        end else begin
            e = expect_out(cur, cyc);
        end
        sb.push_back(e);
        if (r) begin
            cyc  = 0;
            cur  = tbl[0];
            pend = tbl[0];
        end else begin
            if (cyc % 32 == 31) cur = ld ? rec : pend;
            if (ld) pend = rec;
            cyc++;
        end
        @(posedge clk);
        @(negedge clk);
        check_out();
    endtask

    task automatic load_at(input vec_t rec, input int unsigned pos);
        while (cyc % 32 != pos) step(1'b0, rec, 1'b0);
        step(1'b1, rec, 1'b0);
    endtask

    task automatic finish_frames();
        while (cyc % 32 != 0) step(1'b0, tbl[0], 1'b0);
        repeat (32) step(1'b0, tbl[0], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{value: 16'h0000, dp: 4'b0000, lz: 1'b0, seg: {7'h7E, 7'h7E, 7'h7E, 7'h7E}, pos: 0};
        tbl[1] = '{value: 16'h1234, dp: 4'b0000, lz: 1'b0, seg: {7'h30, 7'h6D, 7'h79, 7'h33}, pos: 0};
        tbl[2] = '{value: 16'hABCD, dp: 4'b0000, lz: 1'b0, seg: {7'h77, 7'h1F, 7'h4E, 7'h3D}, pos: 10};
        tbl[3] = '{value: 16'h00F0, dp: 4'b0000, lz: 1'b0, seg: {7'h7E, 7'h7E, 7'h47, 7'h7E}, pos: 31};
        tbl[4] = '{value: 16'h0007, dp: 4'b0100, lz: 1'b1, seg: {7'h00, 7'h00, 7'h00, 7'h70}, pos: 5};
        tbl[5] = '{value: 16'h0000, dp: 4'b0000, lz: 1'b1, seg: {7'h00, 7'h00, 7'h00, 7'h7E}, pos: 31};
        tbl[6] = '{value: 16'h5E89, dp: 4'b1010, lz: 1'b1, seg: {7'h5B, 7'h4F, 7'h7F, 7'h7B}, pos: 17};
        tbl[7] = '{value: 16'h0608, dp: 4'b0001, lz: 1'b1, seg: {7'h00, 7'h5F, 7'h7E, 7'h7F}, pos: 26};

        cyc  = 0;
        cur  = tbl[0];
        pend = tbl[0];

        // Reset held three cycles: all outputs inactive
        phase = "reset";
        repeat (3) step(1'b0, tbl[0], 1'b1);

        // Table: load each setting at its frame position, then watch it through a full frame
        for (int v = 1; v < 8; v++) begin
            phase = $sformatf("vec%0d", v);
            load_at(tbl[v], tbl[v].pos);
            finish_frames();
        end

        // Two loads in one frame, the second on the boundary itself: the boundary load wins
        phase = "last_wins_boundary";
        load_at(tbl[1], 3);
        load_at(tbl[3], 31);
        finish_frames();

        // Two loads between boundaries: the later one reaches the display
        phase = "last_wins_mid";
        load_at(tbl[2], 3);
        load_at(tbl[6], 20);
        finish_frames();

        // Pending shadow, then reset in the digit-2 slot (with load held high): display returns to zero
        phase = "mid_reset";
        load_at(tbl[1], 5);
        while (cyc % 32 != 20) step(1'b0, tbl[1], 1'b0);
        step(1'b0, tbl[2], 1'b1);
        step(1'b1, tbl[2], 1'b1);
        phase = "after_reset";
        repeat (64) step(1'b0, tbl[0], 1'b0);

        phase = "drain";
        if (sb.size() != 0) begin
            chk_cnt++;
            $display("FAIL drain %0d expectations left, want 0", sb.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
